// File: rtl/wave_conditioner_if.sv
// Signal bundle between the frequency-meter input front end and its user.
// master: drives the raw waves and controls; slave: the conditioner itself.
interface wave_conditioner_if;
  localparam int unsigned CNT_W = 32;

  logic             A;
  logic             B;
  logic             en;
  logic             cnt_clr;
  logic             A_clean;
  logic             B_clean;
  logic             A_rise;
  logic             A_fall;
  logic             B_rise;
  logic             B_fall;
  logic             A_lost;
  logic             B_lost;
  logic [CNT_W-1:0] edge_cnt_a;
  logic [CNT_W-1:0] edge_cnt_b;

  modport master (
    output A, B, en, cnt_clr,
    input  A_clean, B_clean, A_rise, A_fall, B_rise, B_fall,
    input  A_lost, B_lost, edge_cnt_a, edge_cnt_b
  );

  modport slave (
    input  A, B, en, cnt_clr,
    output A_clean, B_clean, A_rise, A_fall, B_rise, B_fall,
    output A_lost, B_lost, edge_cnt_a, edge_cnt_b
  );
endinterface

// File: rtl/wave_conditioner.sv
// Input front end of the frequency meter: per channel (A, B) a synchroniser,
// glitch filter, registered rise/fall pulses and a loss-of-signal watchdog.
// Optional rising-edge counters are built when WAVE_COND_STATS_EN is defined;
// otherwise edge_cnt_a/edge_cnt_b read 0 and cnt_clr is ignored.
module wave_conditioner #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT     = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  wave_conditioner_if.slave bus
);

  localparam int unsigned NCH   = 2;
  localparam int unsigned FC_W  = 8;
  localparam int unsigned FCX_W = FC_W + 1;
  localparam int unsigned WD_W  = 32;
  localparam int unsigned CNT_W = 32;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   clean_w;
  logic [NCH-1:0]   rise_w;
  logic [NCH-1:0]   fall_w;
  logic [NCH-1:0]   lost_w;
  logic [CNT_W-1:0] cnt_w [NCH];

  assign raw = {bus.B, bus.A};

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [FC_W-1:0]        fc_q;
    logic                   clean_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   lost_q;
    logic [WD_W-1:0]        wd_q;
    logic [WD_W-1:0]        wd_nxt;
    logic                   s;
    logic                   flip;

    assign s = sync_q[SYNC_STAGES-1];

    // The clean level changes on the FILT_LEN-th consecutive differing sample.
    assign flip = bus.en && (s != clean_q) &&
                  ((FCX_W'(fc_q) + FCX_W'(1)) == FCX_W'(FILT_LEN));

    // Synchroniser chain; free-running whenever out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], raw[ch]};
      end
    end

    // Glitch filter, clean level and single-cycle edge pulses.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fc_q    <= '0;
        clean_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else if (!bus.en) begin
        fc_q   <= '0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= flip && s;
        fall_q <= flip && !s;
        if (flip || (s == clean_q)) begin
          fc_q <= '0;
        end else begin
          fc_q <= fc_q + FC_W'(1);
        end
        if (flip) begin
          clean_q <= s;
        end
      end
    end

    // Next watchdog value: cleared by a clean edge, otherwise saturating count.
    always_comb begin
      wd_nxt = wd_q;
      if (flip) begin
        wd_nxt = '0;
      end else if (wd_q < WD_W'(TIMEOUT)) begin
        wd_nxt = wd_q + WD_W'(1);
      end
    end

    // Watchdog counter and lost flag, both held at 0 while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wd_q   <= '0;
        lost_q <= 1'b0;
      end else if (!bus.en) begin
        wd_q   <= '0;
        lost_q <= 1'b0;
      end else begin
        wd_q   <= wd_nxt;
        lost_q <= (wd_nxt == WD_W'(TIMEOUT));
      end
    end

`ifdef WAVE_COND_STATS_EN
    logic [CNT_W-1:0] cnt_q;

    // Rising-edge counter; a clear wins over a coincident rise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (bus.cnt_clr) begin
        cnt_q <= '0;
      end else if (rise_q) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end

    assign cnt_w[ch] = cnt_q;
`else
    assign cnt_w[ch] = '0;
`endif

    assign clean_w[ch] = clean_q;
    assign rise_w[ch]  = rise_q;
    assign fall_w[ch]  = fall_q;
    assign lost_w[ch]  = lost_q;
  end

`ifndef WAVE_COND_STATS_EN
  logic unused_cnt_clr;
  assign unused_cnt_clr = bus.cnt_clr;
`endif

  assign bus.A_clean    = clean_w[0];
  assign bus.B_clean    = clean_w[1];
  assign bus.A_rise     = rise_w[0];
  assign bus.B_rise     = rise_w[1];
  assign bus.A_fall     = fall_w[0];
  assign bus.B_fall     = fall_w[1];
  assign bus.A_lost     = lost_w[0];
  assign bus.B_lost     = lost_w[1];
  assign bus.edge_cnt_a = cnt_w[0];
  assign bus.edge_cnt_b = cnt_w[1];

endmodule

// File: doc/wave_conditioner.md
Name: wave_conditioner

Overview:
- Input front end of the frequency meter.
- Takes the two raw asynchronous test waves A and B and, per channel:
  - synchronises the wave into the clk domain;
  - rejects glitches shorter than a programmable number of cycles;
  - emits single-cycle rise/fall pulses;
  - flags loss of signal.
- Its outputs A_clean and B_clean replace the raw A and B at the wave-select stage, which feeds the F/T measurement units.

Parameters:
- SYNC_STAGES, 2, synchroniser flip-flops per channel (legal 2..4).
- FILT_LEN, 4, consecutive identical synchronised samples required to change the clean level (legal 1..255; 1 = no filtering).
- TIMEOUT, 50000000, cycles without a clean edge before the channel's lost flag asserts (legal 2..2^32-1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  1  raw wave A, asynchronous to clk.
- B  input  1  raw wave B, asynchronous to clk.
- en  input  1  1 = conditioning active; 0 = hold.
- A_clean  output  1  filtered, synchronised A.
- B_clean  output  1  filtered, synchronised B.
- A_rise  output  1  one-cycle pulse on a 0->1 change of A_clean.
- A_fall  output  1  one-cycle pulse on a 1->0 change of A_clean.
- B_rise  output  1  one-cycle pulse on a 0->1 change of B_clean.
- B_fall  output  1  one-cycle pulse on a 1->0 change of B_clean.
- A_lost  output  1  no A_clean edge for TIMEOUT cycles.
- B_lost  output  1  no B_clean edge for TIMEOUT cycles.
- cnt_clr  input  1  synchronous clear of the edge counters (optional feature).
- edge_cnt_a  output  32  A_clean rising-edge count (optional feature).
- edge_cnt_b  output  32  B_clean rising-edge count (optional feature).

Behaviour:
- Clock, reset and channel independence:
  - One clock, clk. Reset rst_n is asynchronous and active-low.
  - The two channels are identical and independent; the rules below are stated for channel A.
- Reset: all synchroniser flops, filter counters, clean levels, pulses, watchdog counters, lost flags and edge counters go to 0 immediately. Reset asserted mid-operation discards any partial filter count.
- Synchroniser: a SYNC_STAGES-deep flop chain. It runs whenever reset is released, regardless of en. Its last stage is the sample s.
- Filter: a counter fc (8 bit) and the clean level A_clean.
  - s == A_clean: fc <= 0.
  - s != A_clean and fc+1 < FILT_LEN: fc <= fc+1.
  - s != A_clean and fc+1 == FILT_LEN: A_clean <= s and fc <= 0.
  - Any sample equal to A_clean restarts the count, so a glitch lasting fewer than FILT_LEN samples never reaches A_clean.
- Latency: count the first clk edge that samples a new, stable raw level as edge 1. A_clean takes the new value at edge SYNC_STAGES+FILT_LEN. With the defaults this is edge 6.
- Edge pulses:
  - A_rise/A_fall are registered. Each is high for exactly the one cycle in which A_clean first shows its new value, and low otherwise.
  - A_rise and A_fall are never both high.
  - Minimum spacing between pulses is FILT_LEN cycles.
- Watchdog: a 32-bit counter wd.
  - On a clean edge: wd <= 0.
  - Otherwise, if wd < TIMEOUT: wd <= wd+1.
  - At TIMEOUT the counter saturates.
  - A_lost = (wd == TIMEOUT), registered. It asserts TIMEOUT cycles after the last edge, or after reset if no edge occurs.
  - A_lost deasserts in the same cycle as the next A_rise/A_fall.
- en = 0, checked every cycle:
  - fc, wd, A_lost and pulses are forced to 0.
  - A_clean holds its value; the synchroniser keeps running.
  - On return to en = 1, filtering restarts from fc = 0. If s differs from the held A_clean, a pulse follows FILT_LEN cycles later.
- Post-reset: if A is held high through reset release, A_clean rises, with an A_rise pulse, after the normal latency.

Optional Feature:
- Macro: WAVE_COND_STATS_EN.
- Defined:
  - edge_cnt_a/edge_cnt_b increment by 1 in each cycle where A_rise/B_rise is high, wrapping from 2^32-1 to 0.
  - cnt_clr clears both counters at the next edge. Clear has priority: a rise in the clear cycle is not counted.
  - Counting is independent of en; no pulses occur while en = 0 anyway.
- Undefined:
  - Ports remain; edge_cnt_a and edge_cnt_b are tied to 0.
  - cnt_clr is ignored; no counter flops are generated.

Test Plan:
- Latency and pulse width: defaults, A 0->1 stable -> A_clean high at edge 6, A_rise high for exactly 1 cycle at that edge; A 1->0 -> A_fall with identical timing.
- Glitch rejection: FILT_LEN=4; B high for 3 sampled cycles then low -> B_clean stays 0, no pulses; B high for 4 cycles -> B_rise once.
- Period tracking: A square wave of period 20 cycles, 50% duty -> A_rise every 20 cycles, A_fall offset by 10, A_lost stays 0.
- Loss of signal: TIMEOUT=100; A stops toggling after an edge -> A_lost rises exactly 100 cycles later; next edge clears it in the same cycle as the pulse.
- en and reset: en=0 while A toggles -> no pulses, A_clean held, lost=0; rst_n pulsed low mid-filter with fc=2 -> all outputs 0 asynchronously, count restarts.
- Stats (WAVE_COND_STATS_EN): 5 A rises -> edge_cnt_a=5; cnt_clr coinciding with a rise -> count 0; preload 0xFFFFFFFF plus one rise -> 0.
